// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - debug module DMI request/response types and response codes
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

endpackage

// File: rtl/dmi_arbiter_rr_arbiter.sv
// rtl/dmi_arbiter_rr_arbiter.sv - combinational round-robin grant
//
// Purpose: picks the first asserted request scanning upward from last_i+1,
// wrapping modulo N, so the most recently served requester has lowest priority.
//
// Ports:
//   req_i    in   N   request vector
//   last_i   in   IW  index of the last served requester
//   gnt_o    out  N   one-hot grant (all zero when no request)
//   idx_o    out  IW  index of the granted requester
//   valid_o  out  1   at least one request is asserted
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int c;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        // k runs 1..N so the last served requester is examined last.
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_i) + k) % N;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - round-robin sharing of one DMI channel among NUM_REQ masters
//
// Purpose: grants one master at a time, forwards its request downstream, routes
// the response back to that master, and substitutes an error response if the
// downstream side does not answer within TIMEOUT cycles (0 = never). A response
// that arrives after a timeout is swallowed in DRAIN.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   req_i / req_valid_i / req_ready_o      per-master request handshake
//   resp_o / resp_valid_o / resp_ready_i   shared response payload, per-master handshake
//   dmi_req_o / dmi_req_valid_o / dmi_req_ready_i      downstream request
//   dmi_resp_i / dmi_resp_valid_i / dmi_resp_ready_o   downstream response
//   busy_o     transaction in flight (state != IDLE)
//   owner_o    current or last granted master
//   timeout_o  one-cycle pulse, high in the first RET cycle of a timed-out transaction
module dmi_arbiter
    import dm::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  dm::dmi_req_t [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output dm::dmi_resp_t                     resp_o,
    output logic [NUM_REQ-1:0]                resp_valid_o,
    input  logic [NUM_REQ-1:0]                resp_ready_i,
    output dm::dmi_req_t                      dmi_req_o,
    output logic                              dmi_req_valid_o,
    input  logic                              dmi_req_ready_i,
    input  dm::dmi_resp_t                     dmi_resp_i,
    input  logic                              dmi_resp_valid_i,
    output logic                              dmi_resp_ready_o,
    output logic                              busy_o,
    output logic [$clog2(NUM_REQ)-1:0]        owner_o,
    output logic                              timeout_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TSAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_RET,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   owner_q, owner_d;
    dmi_req_t        dmi_req_q, dmi_req_d;
    dmi_resp_t       resp_q, resp_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            drain_q, drain_d;
    logic            timeout_q, timeout_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               expiry;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req_i   (req_valid_i),
        .last_i  (rr_q),
        .gnt_o   (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    assign expiry = (TIMEOUT != 0) && (timer_q == TLAST);

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        owner_d          = owner_q;
        dmi_req_d        = dmi_req_q;
        resp_d           = resp_q;
        timer_d          = timer_q;
        drain_d          = drain_q;
        timeout_d        = 1'b0;
        req_ready_o      = '0;
        resp_valid_o     = '0;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = gnt_oh;
                if (gnt_any) begin
                    dmi_req_d = req_i[gnt_idx];
                    owner_d   = gnt_idx;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    timer_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                dmi_resp_ready_o = 1'b1;
                // A real response in the expiry cycle takes precedence.
                if (dmi_resp_valid_i) begin
                    resp_d  = dmi_resp_i;
                    state_d = S_RET;
                end else if (expiry) begin
                    resp_d.data = '0;
                    resp_d.resp = DTM_ERR;
                    timeout_d   = 1'b1;
                    drain_d     = 1'b1;
                    state_d     = S_RET;
                end else if (timer_q != TSAT) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RET: begin
                resp_valid_o[owner_q] = 1'b1;
                if (resp_ready_i[owner_q]) begin
                    rr_d    = owner_q;
                    state_d = drain_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The late response still owes a handshake downstream; eat it.
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    drain_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rr_q      <= IW'(NUM_REQ - 1);
            owner_q   <= '0;
            dmi_req_q <= '0;
            resp_q    <= '0;
            timer_q   <= '0;
            drain_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            dmi_req_q <= dmi_req_d;
            resp_q    <= resp_d;
            timer_q   <= timer_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
        end
    end

    assign dmi_req_o = dmi_req_q;
    assign resp_o    = resp_q;
    assign busy_o    = (state_q != S_IDLE);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb/tb_dmi_arbiter.sv - directed self-checking bench for dmi_arbiter
module tb_dmi_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    dm::dmi_req_t [1:0] req;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    dm::dmi_resp_t      resp;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    dm::dmi_req_t       dmi_req;
    logic               dmi_req_valid;
    logic               dmi_req_ready;
    dm::dmi_resp_t      dmi_resp;
    logic               dmi_resp_valid;
    logic               dmi_resp_ready;
    logic               busy;
    logic [0:0]         owner;
    logic               timeout;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmi_arbiter #(
        .NUM_REQ (2),
        .TIMEOUT (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .dmi_req_o        (dmi_req),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_resp_i       (dmi_resp),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .busy_o           (busy),
        .owner_o          (owner),
        .timeout_o        (timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_dmi_req_valid", dmi_req_valid, 0);
        check_eq("rst_dmi_resp_ready", dmi_resp_ready, 0);
        check_eq("rst_dmi_req", dmi_req, 0);
        check_eq("rst_resp", resp, 0);
        check_eq("rst_timeout", timeout, 0);
    endtask

    // Starts and ends at a negedge in IDLE. stall = REQ cycles with ready low,
    // rdelay = RESP cycles before the downstream response is presented.
    task automatic txn(input logic [1:0] vld, input int exp_own, input logic [31:0] rdata,
                       input int stall, input int rdelay);
        logic [1:0]   oh;
        dm::dmi_req_t exp_req;
        oh      = 2'b01 << exp_own;
        exp_req = req[exp_own];
        req_valid = vld;
        #1;
        check_eq("grant", req_ready, oh);
        check_eq("idle_busy", busy, 0);
        @(negedge clk);
        dmi_req_ready = (stall == 0);
        #1;
        check_eq("owner", owner, exp_own);
        check_eq("dmi_req_valid", dmi_req_valid, 1);
        check_eq("dmi_req", dmi_req, exp_req);
        check_eq("no_grant_busy", req_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (i == stall - 1) dmi_req_ready = 1'b1;
            #1;
            check_eq("stall_valid", dmi_req_valid, 1);
            check_eq("stall_req", dmi_req, exp_req);
            check_eq("stall_timeout", timeout, 0);
        end
        @(negedge clk);
        for (int i = 0; i < rdelay; i++) begin
            #1;
            check_eq("resp_wait_ready", dmi_resp_ready, 1);
            check_eq("resp_wait_timeout", timeout, 0);
            check_eq("resp_wait_valid", resp_valid, 0);
            @(negedge clk);
        end
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = rdata;
        dmi_resp.resp  = dm::DTM_SUCCESS;
        #1;
        check_eq("dmi_resp_ready", dmi_resp_ready, 1);
        @(negedge clk);
        dmi_resp_valid = 1'b0;
        #1;
        check_eq("resp_valid", resp_valid, oh);
        check_eq("resp_data", resp.data, rdata);
        check_eq("resp_code", resp.resp, dm::DTM_SUCCESS);
        check_eq("ret_timeout", timeout, 0);
        check_eq("ret_dmi_resp_ready", dmi_resp_ready, 0);
        @(negedge clk);
        #1;
        check_eq("done_busy", busy, 0);
        check_eq("done_dmi_resp_ready", dmi_resp_ready, 0);
        req_valid = 2'b00;
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 2'b00;
        resp_ready     = 2'b11;
        dmi_req_ready  = 1'b1;
        dmi_resp       = '0;
        dmi_resp_valid = 1'b0;
        req[0].addr    = 7'h10;
        req[0].op      = dm::DTM_WRITE;
        req[0].data    = 32'hDEADBEEF;
        req[1].addr    = 7'h22;
        req[1].op      = dm::DTM_READ;
        req[1].data    = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);

        // Both masters continuously requesting: strict alternation from master 0.
        txn(2'b11, 0, 32'h1111_0000, 0, 0);
        txn(2'b11, 1, 32'h2222_0001, 0, 0);
        txn(2'b11, 0, 32'h3333_0002, 0, 0);
        txn(2'b11, 1, 32'h4444_0003, 0, 0);

        // Single master 0, everything ready immediately, response 0/success.
        txn(2'b01, 0, 32'h0000_0000, 0, 0);

        // Response lands in the same cycle the timer would expire.
        txn(2'b10, 1, 32'hCAFE_F00D, 0, 7);

        // Timeout with no response, then a late response swallowed in DRAIN.
        req_valid = 2'b01;
        #1;
        check_eq("to_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("to_dmi_req_valid", dmi_req_valid, 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("to_wait_timeout", timeout, 0);
            check_eq("to_wait_resp_valid", resp_valid, 0);
            @(negedge clk);
        end
        #1;
        check_eq("to_pulse", timeout, 1);
        check_eq("to_resp_valid", resp_valid, 2'b01);
        check_eq("to_resp", resp, {32'h0, 2'h2});
        req_valid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("drain_timeout", timeout, 0);
            check_eq("drain_ready", dmi_resp_ready, 1);
            check_eq("drain_resp_valid", resp_valid, 0);
            check_eq("drain_no_grant", req_ready, 0);
            check_eq("drain_busy", busy, 1);
        end
        @(negedge clk);
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'h0000_0BAD;
        dmi_resp.resp  = dm::DTM_SUCCESS;
        #1;
        check_eq("late_not_forwarded", resp_valid, 0);
        check_eq("late_no_grant", req_ready, 0);
        @(negedge clk);
        dmi_resp_valid = 1'b0;
        #1;
        check_eq("post_drain_busy", busy, 0);
        txn(2'b10, 1, 32'h1234_5678, 0, 0);

        // Downstream request backpressure for 5 cycles.
        txn(2'b01, 0, 32'h5555_AAAA, 5, 0);

        // Reset during RESP abandons master 1; afterwards master 0 wins.
        req_valid = 2'b10;
        #1;
        check_eq("abort_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        txn(2'b11, 0, 32'h7777_8888, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
